// File: rtl/pdm_cic_decimator.sv
// N-stage CIC decimator: 1-bit PDM stream in, signed 17-bit PCM out at PDMCLK/R, plus the FIR_COMB sample clock.
// Defining CIC_DC_REMOVE_EN adds a first-order DC blocker at the output rate, ahead of saturation.
module pdm_cic_decimator #(
   parameter int N        = 4,
   parameter int R        = 16,
   parameter int DC_SHIFT = 8
) (
   input  logic        PDMCLK,
   input  logic        RST,
   input  logic        pdm_in,
   output logic [16:0] cic_out,
   output logic        cic_valid,
   output logic        cic_clk_out,
   output logic        cic_sat
);
   localparam int LR = $clog2(R);
   localparam int W  = 2 + N * LR;
   localparam int SH = (W > 18) ? (W - 18) : 0;
   localparam int CW = (LR > 0) ? LR : 1;

   logic                pdm_q_r;
   logic signed [W-1:0] integ_r [1:N];
   logic signed [W-1:0] comb_r  [0:N];
   logic signed [W-1:0] dly_r   [1:N];
   logic [CW-1:0]       cnt_r;
   logic                dec_q_r;
   logic                dec_s;
   logic signed [W-1:0] x_s;
   logic signed [W-1:0] scaled_s;
   logic signed [23:0]  s_s;
   logic signed [23:0]  y_s;
   logic [17:0]         sat_s;

   // Clip to the 17-bit signed range; bit 17 of the result flags a clip.
   function automatic logic [17:0] sat17(input logic signed [23:0] v);
      logic [17:0] r;
      if (v > 24'sd65535) begin
         r = {1'b1, 17'h0FFFF};
      end else if (v < -24'sd65536) begin
         r = {1'b1, 17'h10000};
      end else begin
         r = {1'b0, v[16:0]};
      end
      return r;
   endfunction

   // Input mapping and decimation strobe.
   always_comb begin
      dec_s = (cnt_r == CW'(R - 1));
      if (pdm_q_r) begin
         x_s = {{(W-1){1'b0}}, 1'b1};
      end else begin
         x_s = {W{1'b1}};
      end
   end

   // Integrator chain every cycle, pipelined comb chain on decimation edges, phase counter.
   always_ff @(posedge PDMCLK) begin
      if (RST) begin
         pdm_q_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         dec_q_r <= 1'b0;
         comb_r[0] <= {W{1'b0}};
         for (int k = 1; k <= N; k++) begin
            integ_r[k] <= {W{1'b0}};
            comb_r[k]  <= {W{1'b0}};
            dly_r[k]   <= {W{1'b0}};
         end
      end else begin
         pdm_q_r    <= pdm_in;
         dec_q_r    <= dec_s;
         cnt_r      <= dec_s ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
         integ_r[1] <= integ_r[1] + x_s;
         for (int k = 2; k <= N; k++) begin
            integ_r[k] <= integ_r[k] + integ_r[k-1];
         end
         if (dec_s) begin
            comb_r[0] <= integ_r[N];
            for (int k = 1; k <= N; k++) begin
               dly_r[k]  <= comb_r[k-1];
               comb_r[k] <= comb_r[k-1] - dly_r[k];
            end
         end
      end
   end

   assign scaled_s = comb_r[N] >>> SH;

   generate
      if (W < 24) begin : g_sext
         assign s_s = {{(24-W){scaled_s[W-1]}}, scaled_s};
      end else begin : g_trunc
         assign s_s = scaled_s[23:0];
      end
   endgenerate

`ifdef CIC_DC_REMOVE_EN
   logic signed [23:0] s_prev_r;
   logic signed [23:0] y_prev_r;

   // DC blocker: y[n] = s[n] - s[n-1] + y[n-1] - (y[n-1] >>> DC_SHIFT).
   always_comb begin
      y_s = s_s - s_prev_r + y_prev_r - (y_prev_r >>> DC_SHIFT);
   end

   // Blocker state advances once per output sample.
   always_ff @(posedge PDMCLK) begin
      if (RST) begin
         s_prev_r <= 24'sd0;
         y_prev_r <= 24'sd0;
      end else if (dec_q_r) begin
         s_prev_r <= s_s;
         y_prev_r <= y_s;
      end else begin
         s_prev_r <= s_prev_r;
         y_prev_r <= y_prev_r;
      end
   end
`else
   // Without the blocker the scaled comb output goes straight to saturation.
   always_comb begin
      y_s = s_s;
   end
`endif

   assign sat_s = sat17(y_s);

   // Registered outputs; the sample clock is high while the next count lies in {R/2+1..R-1, 0}.
   always_ff @(posedge PDMCLK) begin
      if (RST) begin
         cic_out     <= 17'd0;
         cic_valid   <= 1'b0;
         cic_clk_out <= 1'b0;
         cic_sat     <= 1'b0;
      end else begin
         cic_valid   <= dec_q_r;
         cic_clk_out <= (cnt_r >= CW'(R / 2));
         if (dec_q_r) begin
            cic_out <= sat_s[16:0];
            cic_sat <= sat_s[17];
         end else begin
            cic_out <= cic_out;
            cic_sat <= cic_sat;
         end
      end
   end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at default parameters: reset, output timing, steady-state levels, mid-sample reset.
module tb_pdm_cic_decimator;
   logic        PDMCLK = 1'b0;
   logic        RST    = 1'b1;
   logic        pdm_in = 1'b0;
   logic [16:0] cic_out;
   logic        cic_valid;
   logic        cic_clk_out;
   logic        cic_sat;

   int errors = 0;
   int checks = 0;
   int mode   = 1;   // 0 all zeros, 1 all ones, 2 alternating

   typedef struct packed {
      logic               chk;
      logic signed [31:0] out;
      logic               sat;
   } exp_t;

   exp_t sb[$];

   always #5 PDMCLK = ~PDMCLK;

   pdm_cic_decimator dut (
      .PDMCLK      (PDMCLK),
      .RST         (RST),
      .pdm_in      (pdm_in),
      .cic_out     (cic_out),
      .cic_valid   (cic_valid),
      .cic_clk_out (cic_clk_out),
      .cic_sat     (cic_sat)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge PDMCLK);
      #1;
      pdm_in = (mode == 2) ? ~pdm_in : (mode == 1);
   endtask

   task automatic wait_valid(input int limit, output int edges);
      edges = 0;
      do begin
         step();
         edges++;
      end while (!cic_valid && edges < limit);
   endtask

   task automatic collect(input int n, input string tag);
      exp_t e;
      int   edges;
      for (int i = 0; i < n; i++) begin
         wait_valid(40, edges);
         check({tag, "_interval"}, edges, (i == 0) ? 17 : 16);
         if (cic_valid && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
               check({tag, "_out"}, $signed(cic_out), e.out);
               check({tag, "_sat"}, cic_sat, e.sat);
            end
         end
      end
   endtask

   task automatic run_pattern(input int m, input string tag);
      exp_t e;
      mode   = m;
      pdm_in = (m != 0);
      RST    = 1'b1;
      step();
      RST    = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         e.chk = (i >= 12);
         e.out = (m == 1) ? 32'sd65535 : ((m == 0) ? -32'sd65536 : 32'sd0);
         e.sat = (m == 1);
         sb.push_back(e);
      end
      collect(20, tag);
   endtask

   initial begin
      int edges;
      mode   = 1;
      pdm_in = 1'b1;
      RST    = 1'b1;
      repeat (3) step();
      check("rst_out",   $signed(cic_out), 32'sd0);
      check("rst_valid", cic_valid,   1'b0);
      check("rst_clk",   cic_clk_out, 1'b0);
      check("rst_sat",   cic_sat,     1'b0);

      RST = 1'b0;
      for (int k = 1; k <= 48; k++) begin
         step();
         check("tim_valid", cic_valid,   (k >= 17) && (k % 16 == 1));
         check("tim_clk",   cic_clk_out, (k % 16 >= 9) || (k % 16 == 0));
      end

      run_pattern(1, "ones");
      run_pattern(0, "zeros");
      run_pattern(2, "alt");

      // Reset lands on the decimation edge that would have produced the next sample.
      mode = 1;
      wait_valid(40, edges);
      check("mid_sync", cic_valid, 1'b1);
      repeat (14) step();
      RST = 1'b1;
      step();
      check("mid_out",   $signed(cic_out), 32'sd0);
      check("mid_valid", cic_valid,   1'b0);
      check("mid_clk",   cic_clk_out, 1'b0);
      check("mid_sat",   cic_sat,     1'b0);
      RST = 1'b0;
      wait_valid(40, edges);
      check("mid_first", edges, 17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
